// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter and the memory controller that
// drives the same request bundle.
package dmem_arbiter_pkg;

    typedef enum logic {ARB, LOCK} arb_state_e;

    typedef enum logic {CORE, EXT} requester_e;

    typedef struct packed {
        logic        cs;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; under contention the
// requester that did not win last time is chosen. Grant is one-hot {ext, core}.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  requester_e last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = (last == CORE) ? 2'b10 : 2'b01;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and an
// external requester, with a bounded ext burst lock and registered read return.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_wr,
    input  logic [3:0]  core_mask,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        ext_req,
    input  logic        ext_wr,
    input  logic [3:0]  ext_mask,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic        ext_lock,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_wr,
    input  logic [31:0] mem_data_rd,
    output arb_state_e  arb_state
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    arb_state_e       state;
    requester_e       last_gnt;
    logic [CNT_W-1:0] lock_cnt;
    logic [1:0]       rr_gnt;
    logic             core_gnt;
    logic             ext_win;
    logic             forced_slot;
    mem_req_t         mux;

    rr_pick2 u_pick (
        .req0 (core_req),
        .req1 (ext_req),
        .last (last_gnt),
        .gnt  (rr_gnt)
    );

    // In LOCK ext has priority unless its budget is spent and the core waits.
    always_comb begin
        forced_slot = (state == LOCK) && (lock_cnt == CNT_MAX) && core_req;
        core_gnt    = 1'b0;
        ext_win     = 1'b0;
        if (state == ARB) begin
            core_gnt = rr_gnt[0];
            ext_win  = rr_gnt[1];
        end else if (forced_slot) begin
            core_gnt = 1'b1;
        end else if (ext_req) begin
            ext_win = 1'b1;
        end else begin
            core_gnt = core_req;
        end
    end

    always_comb begin
        mux = '0;
        if (core_gnt) begin
            mux.cs    = 1'b1;
            mux.wr    = core_wr;
            mux.mask  = core_mask;
            mux.addr  = core_addr;
            mux.wdata = core_wdata;
        end else if (ext_win) begin
            mux.cs    = 1'b1;
            mux.wr    = ext_wr;
            mux.mask  = ext_mask;
            mux.addr  = ext_addr;
            mux.wdata = ext_wdata;
        end
    end

    assign mem_cs      = mux.cs;
    assign mem_wr      = mux.wr;
    assign mem_mask    = mux.mask;
    assign mem_addr    = mux.addr;
    assign mem_data_wr = mux.wdata;
    assign ext_gnt     = ext_win;
    assign core_stall  = core_req & ~core_gnt;
    assign arb_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            last_gnt <= EXT;
            lock_cnt <= '0;
        end else begin
            if (core_gnt) begin
                last_gnt <= CORE;
            end else if (ext_win) begin
                last_gnt <= EXT;
            end
            case (state)
                ARB: begin
                    if (ext_win && ext_lock) begin
                        state    <= LOCK;
                        lock_cnt <= CNT_W'(1);
                    end else begin
                        lock_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (ext_win && ext_lock) begin
                        if (lock_cnt != CNT_MAX) begin
                            lock_cnt <= lock_cnt + CNT_W'(1);
                        end
                    end else begin
                        state    <= ARB;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ARB;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Read data is captured at the grant edge; rdata holds until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rvalid <= 1'b0;
            ext_rvalid  <= 1'b0;
            core_rdata  <= '0;
            ext_rdata   <= '0;
        end else begin
            core_rvalid <= core_gnt & ~core_wr;
            ext_rvalid  <= ext_win & ~ext_wr;
            if (core_gnt && !core_wr) begin
                core_rdata <= mem_data_rd;
            end
            if (ext_win && !ext_wr) begin
                ext_rdata <= mem_data_rd;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single-port data memory between the core's load/store path and an external requester (program loader / debug DMA). It sits between the memory controller's `cs/wr/mask/addr/data_wr` outputs and the data memory, grants one requester per cycle, and registers read data back to the winner. It raises `core_stall` so the core holds its PC and register write while it waits. It supports a bounded ext burst lock with a starvation guard.

## Interface
- `MAX_LOCK`, 16: maximum consecutive locked ext grants before a forced core slot.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `core_req`  in  1  core memory access request (`cs` from memory controller).
- `core_wr`  in  1  core write enable.
- `core_mask`  in  4  core byte mask.
- `core_addr`  in  32  core byte address.
- `core_wdata`  in  32  core write data.
- `core_stall`  out  1  `core_req & ~core_gnt`.
- `core_rvalid`  out  1  core read data valid.
- `core_rdata`  out  32  core read data.
- `ext_req`, `ext_wr`, `ext_mask[3:0]`, `ext_addr[31:0]`, `ext_wdata[31:0]`  in  external request, same meaning as core.
- `ext_lock`  in  1  request that ext keep ownership next cycle.
- `ext_gnt`  out  1  ext access accepted this cycle.
- `ext_rvalid`  out  1  ext read data valid.
- `ext_rdata`  out  32  ext read data.
- `mem_cs`, `mem_wr`, `mem_mask[3:0]`, `mem_addr[31:0]`, `mem_data_wr[31:0]`  out  muxed memory port.
- `mem_data_rd`  in  32  memory read data, combinational from `mem_addr`.

## Operation
- Grants are combinational within the request cycle. The memory access happens in the grant cycle. A write commits at the next `clk` edge.
- FSM states:
  - `ARB`: round-robin between requesters.
  - `LOCK`: ext owns the memory.
- `ARB` grant rules:
  - One requester: that requester wins.
  - Both requesting: the requester not equal to `last_gnt` wins.
  - After every grant, `last_gnt` updates to the winner.
- `ARB` → `LOCK` when ext is granted with `ext_lock=1`. `lock_cnt` loads 1.
- In `LOCK`:
  - Ext gets priority when `ext_req=1`. `lock_cnt` increments on every ext grant.
  - If `ext_req=0`, or `ext_lock=0` on a granted cycle, the FSM returns to `ARB` after that cycle.
  - When `lock_cnt == MAX_LOCK` and `core_req=1`, the core gets the next cycle (forced slot). The FSM returns to `ARB` with `last_gnt=CORE`.
- No request granted: `mem_cs=0`, and all other `mem_*` outputs are 0.
- Read return:
  - A granted access with `wr=0` registers `mem_data_rd` into the winner's `*_rdata`.
  - The winner's `*_rvalid` pulses 1 on the following cycle.
  - `*_rdata` holds its value until the next read for that requester.
  - Writes produce no `rvalid`.

## Timing
- Reset values:
  - State `ARB`, `last_gnt=EXT` (core wins the first contention), `lock_cnt=0`.
  - All `*_rvalid=0`, all `*_rdata=0`.
  - `ext_gnt=0`, `mem_cs=0`, `core_stall=core_req`, which is 0 with no requests.
- Latency:
  - Grant: 0 cycles.
  - Read data: 1 cycle after the grant edge.
  - Uncontended throughput: 1 access per cycle.
- A requester must hold its request fields stable until granted.
- The core stall is at most 1 cycle in `ARB` contention, and at most `MAX_LOCK` cycles under lock.
- Simultaneous requests on the cycle a lock ends: normal round-robin with `last_gnt=EXT`, so the core wins.
- `rst` mid-burst: the FSM returns to `ARB` at the edge. A pending `rvalid` is suppressed (0 the cycle after reset). A write granted in the reset cycle is not guaranteed to commit, because the memory is also reset.
- `lock_cnt` width is `$clog2(MAX_LOCK+1)`. It saturates at `MAX_LOCK` and never wraps.

## Structure
- A shared package carries:
  - `typedef enum logic {ARB, LOCK} arb_state_e`.
  - `typedef enum logic {CORE, EXT} requester_e`.
  - `typedef struct packed {cs, wr, mask, addr, wdata} mem_req_t`, reused by the memory controller.
- Sub-module `rr_pick2`: combinational two-way round-robin picker over (`req0`, `req1`, `last`), returning a one-hot grant.
- The top level holds the FSM, the lock counter, the request mux and the read-return registers.

## Test plan
- Core-only load, addr 0x10 holding 0xDEADBEEF:
  - `core_stall=0`, `mem_cs=1` in the same cycle.
  - Next cycle `core_rvalid=1`, `core_rdata=0xDEADBEEF`.
- Both request on the first cycle after reset:
  - Core granted first.
  - Next cycle (both still requesting): ext granted and `core_stall=0` is not expected.
  - Check alternation over 6 cycles: C,E,C,E,C,E.
- Ext write burst, `ext_lock=1`, `MAX_LOCK=4`, core requesting throughout:
  - Ext granted for 4 cycles, with `core_stall=1` during those cycles.
  - Cycle 5: core granted.
  - Cycle 6: ext granted again.
- Ext write 0x12345678 to 0x20 with mask 4'b0011, then core read of 0x20:
  - Core reads 0x00005678, assuming the location was previously 0.
- Assert `rst` during a locked ext read:
  - Next cycle `ext_rvalid=0`, state `ARB`.
  - The first contention after reset grants the core.
- No requests for 5 cycles:
  - `mem_cs=0` and all `mem_*` outputs are 0.
  - All `rvalid=0`.
